// File: rtl/dphy_tx_lane_sequencer_if.sv
// Byte-pair payload stream feeding the D-PHY TX lane sequencer.
interface dphy_tx_lane_sequencer_if;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_D1;
  logic [7:0] in_D0;
  logic       in_ready;

  modport master (output in_valid, in_last, in_D1, in_D0, input in_ready);
  modport slave  (input in_valid, in_last, in_D1, in_D0, output in_ready);
endinterface

// File: rtl/dphy_tx_lane_sequencer.sv
// Two-lane D-PHY TX burst sequencer: LP-11 -> HS request/prepare/zero -> sync -> payload -> trail -> LP-11.
// Every output is registered from the next-state decode so LP transitions are glitch-free.
module dphy_tx_lane_sequencer #(
  parameter int unsigned T_CLK_PRE    = 8,
  parameter int unsigned T_LPX        = 4,
  parameter int unsigned T_HS_PREPARE = 3,
  parameter int unsigned T_HS_ZERO    = 6,
  parameter int unsigned T_HS_TRAIL   = 4,
  parameter int unsigned T_CLK_POST   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  dphy_tx_lane_sequencer_if.slave         in_bus,
  output logic [7:0]                      byte_D1,
  output logic [7:0]                      byte_D0,
  output logic [1:0]                      lp1_out,
  output logic [1:0]                      lp0_out,
  output logic                            lp1_dir,
  output logic                            lp0_dir,
  output logic                            hs_clk_en,
  output logic                            hsxx_clk_en,
  output logic                            hs_data_en,
  output logic                            busy,
  output logic                            underrun
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLK_PRE,
    S_LP01,
    S_LP00,
    S_HS_ZERO,
    S_SYNC,
    S_HS_DATA,
    S_HS_END,
    S_HS_TRAIL,
    S_CLK_POST
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               in_ready_q;
  logic               xfer;

  logic [1:0]         lp_n;
  logic               dir_n, clk_n, data_n, busy_n, rdy_n, und_n;
  logic [7:0]         b1_n, b0_n;

  function automatic logic [CNT_W-1:0] ld(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  assign in_bus.in_ready = in_ready_q;
  assign xfer            = in_bus.in_valid & in_ready_q;

  // Next-state and next-output decode
  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    und_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLK_PRE;
          cnt_n   = ld(T_CLK_PRE);
        end
      end
      S_CLK_PRE: begin
        if (cnt == '0) begin
          state_n = S_LP01;
          cnt_n   = ld(T_LPX);
        end
      end
      S_LP01: begin
        if (cnt == '0) begin
          state_n = S_LP00;
          cnt_n   = ld(T_HS_PREPARE);
        end
      end
      S_LP00: begin
        if (cnt == '0) begin
          state_n = S_HS_ZERO;
          cnt_n   = ld(T_HS_ZERO);
        end
      end
      S_HS_ZERO: begin
        if (cnt == '0) state_n = S_SYNC;
      end
      S_SYNC: begin
        state_n = (xfer && in_bus.in_last) ? S_HS_END : S_HS_DATA;
      end
      S_HS_DATA: begin
        if (!in_bus.in_valid) begin
          state_n = S_HS_END;
          und_n   = 1'b1;
        end else if (in_bus.in_last) begin
          state_n = S_HS_END;
        end
      end
      S_HS_END: begin
        // Last payload (or repeated byte) is on the lanes this cycle; trail starts next
        state_n = S_HS_TRAIL;
        cnt_n   = ld(T_HS_TRAIL);
      end
      S_HS_TRAIL: begin
        if (cnt == '0) begin
          state_n = S_CLK_POST;
          cnt_n   = ld(T_CLK_POST);
        end
      end
      S_CLK_POST: begin
        if (cnt == '0) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    lp_n   = 2'b11;
    dir_n  = 1'b1;
    clk_n  = (state_n != S_IDLE);
    busy_n = (state_n != S_IDLE);
    data_n = 1'b0;
    rdy_n  = 1'b0;
    b1_n   = 8'h00;
    b0_n   = 8'h00;

    case (state_n)
      S_LP01: lp_n = 2'b01;
      S_LP00: lp_n = 2'b00;
      S_HS_ZERO: begin
        lp_n   = 2'b00;
        dir_n  = 1'b0;
        data_n = 1'b1;
      end
      S_SYNC: begin
        lp_n   = 2'b00;
        dir_n  = 1'b0;
        data_n = 1'b1;
        rdy_n  = 1'b1;
        b1_n   = SYNC_BYTE;
        b0_n   = SYNC_BYTE;
      end
      S_HS_DATA, S_HS_END: begin
        lp_n   = 2'b00;
        dir_n  = 1'b0;
        data_n = 1'b1;
        rdy_n  = (state_n == S_HS_DATA);
        b1_n   = xfer ? in_bus.in_D1 : byte_D1;
        b0_n   = xfer ? in_bus.in_D0 : byte_D0;
      end
      S_HS_TRAIL: begin
        lp_n   = 2'b00;
        dir_n  = 1'b0;
        data_n = 1'b1;
        // Trail level is the inverse of the final bit of the last byte sent
        b1_n   = (state == S_HS_END) ? {8{~byte_D1[7]}} : byte_D1;
        b0_n   = (state == S_HS_END) ? {8{~byte_D0[7]}} : byte_D0;
      end
      default: ;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lp1_out     <= 2'b11;
      lp0_out     <= 2'b11;
      lp1_dir     <= 1'b1;
      lp0_dir     <= 1'b1;
      byte_D1     <= 8'h00;
      byte_D0     <= 8'h00;
      hs_clk_en   <= 1'b0;
      hsxx_clk_en <= 1'b0;
      hs_data_en  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lp1_out     <= lp_n;
      lp0_out     <= lp_n;
      lp1_dir     <= dir_n;
      lp0_dir     <= dir_n;
      byte_D1     <= b1_n;
      byte_D0     <= b0_n;
      hs_clk_en   <= clk_n;
      hsxx_clk_en <= clk_n;
      hs_data_en  <= data_n;
      in_ready_q  <= rdy_n;
      busy        <= busy_n;
      underrun    <= und_n;
    end
  end

endmodule

// File: tb/tb_dphy_tx_lane_sequencer.sv
// Randomized bench for dphy_tx_lane_sequencer against a phase-arithmetic burst model.
module tb_dphy_tx_lane_sequencer;

  localparam int unsigned W = 28;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_d, valid_d, last_d;
  logic [7:0] d1_d, d0_d;
  bit         sel;

  dphy_tx_lane_sequencer_if bus_a ();
  dphy_tx_lane_sequencer_if bus_b ();

  logic start_a, start_b;
  assign start_a        = sel ? 1'b0 : start_d;
  assign start_b        = sel ? start_d : 1'b0;
  assign bus_a.in_valid = sel ? 1'b0 : valid_d;
  assign bus_b.in_valid = sel ? valid_d : 1'b0;
  assign bus_a.in_last  = last_d;
  assign bus_b.in_last  = last_d;
  assign bus_a.in_D1    = d1_d;
  assign bus_b.in_D1    = d1_d;
  assign bus_a.in_D0    = d0_d;
  assign bus_b.in_D0    = d0_d;

  logic [7:0] bd1_a, bd0_a, bd1_b, bd0_b;
  logic [1:0] lp1_a, lp0_a, lp1_b, lp0_b;
  logic dir1_a, dir0_a, hclk_a, hxx_a, hdat_a, busy_a, und_a;
  logic dir1_b, dir0_b, hclk_b, hxx_b, hdat_b, busy_b, und_b;

  dphy_tx_lane_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_bus(bus_a),
    .byte_D1(bd1_a), .byte_D0(bd0_a), .lp1_out(lp1_a), .lp0_out(lp0_a),
    .lp1_dir(dir1_a), .lp0_dir(dir0_a), .hs_clk_en(hclk_a), .hsxx_clk_en(hxx_a),
    .hs_data_en(hdat_a), .busy(busy_a), .underrun(und_a)
  );

  dphy_tx_lane_sequencer #(
    .T_CLK_PRE(1), .T_LPX(1), .T_HS_PREPARE(1), .T_HS_ZERO(1), .T_HS_TRAIL(1), .T_CLK_POST(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_bus(bus_b),
    .byte_D1(bd1_b), .byte_D0(bd0_b), .lp1_out(lp1_b), .lp0_out(lp0_b),
    .lp1_dir(dir1_b), .lp0_dir(dir0_b), .hs_clk_en(hclk_b), .hsxx_clk_en(hxx_b),
    .hs_data_en(hdat_b), .busy(busy_b), .underrun(und_b)
  );

  logic [W-1:0] obs_a, obs_b;
  assign obs_a = {lp1_a, lp0_a, dir1_a, dir0_a, hclk_a, hxx_a, hdat_a, busy_a,
                  bus_a.in_ready, und_a, bd1_a, bd0_a};
  assign obs_b = {lp1_b, lp0_b, dir1_b, dir0_b, hclk_b, hxx_b, hdat_b, busy_b,
                  bus_b.in_ready, und_b, bd1_b, bd0_b};

  int n_vec = 0;
  int n_err = 0;
  int burst_id = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  function automatic logic [W-1:0] mk(input logic [1:0] lp, input logic dir, input logic clk_en,
                                      input logic data_en, input logic bsy, input logic rdy,
                                      input logic und, input logic [7:0] b1, input logic [7:0] b0);
    return {lp, lp, dir, dir, clk_en, clk_en, data_en, bsy, rdy, und, b1, b0};
  endfunction

  function automatic logic [W-1:0] obs();
    return sel ? obs_b : obs_a;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One burst: n pairs with last on the n-th, or underrun after u accepted pairs (u>0).
  task automatic run_burst(input int n, input int u, input bit hold, input bit noise);
    int t_cp, t_lpx, t_prep, t_zero, t_trail, t_post;
    int pre, k, e_c, tr, post, fin, idx, i;
    logic [W-1:0] ex;
    logic [7:0] l1, l0;
    t_cp   = sel ? 1 : 8;
    t_lpx  = sel ? 1 : 4;
    t_prep = sel ? 1 : 3;
    t_zero = sel ? 1 : 6;
    t_trail = sel ? 1 : 4;
    t_post = sel ? 1 : 8;
    pre  = t_cp + t_lpx + t_prep + t_zero;
    k    = (u > 0) ? u : n;
    e_c  = (u > 0) ? pre + u + 1 : pre + n;
    tr   = e_c + 1;
    post = tr + t_trail;
    fin  = post + t_post;
    l1   = q1[k-1];
    l0   = q0[k-1];
    burst_id++;

    @(posedge clk) #1;
    check_eq($sformatf("b%0d_idle", burst_id), obs(), mk(2'b11, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    start_d = 1'b1;
    valid_d = noise ? 1'($urandom_range(0, 1)) : 1'b0;

    for (int c = 0; c < fin; c++) begin
      @(posedge clk) #1;
      if (c < t_cp)                       ex = mk(2'b11, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00);
      else if (c < t_cp + t_lpx)          ex = mk(2'b01, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00);
      else if (c < t_cp + t_lpx + t_prep) ex = mk(2'b00, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00);
      else if (c < pre)                   ex = mk(2'b00, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00);
      else if (c == pre)                  ex = mk(2'b00, 0, 1, 1, 1, 1, 0, 8'hB8, 8'hB8);
      else if (c <= e_c) begin
        idx = c - pre - 1;
        if (idx > k - 1) idx = k - 1;
        ex = mk(2'b00, 0, 1, 1, 1, logic'(c < e_c), logic'((u > 0) && (c == e_c)), q1[idx], q0[idx]);
      end
      else if (c < post)                  ex = mk(2'b00, 0, 1, 1, 1, 0, 0, {8{~l1[7]}}, {8{~l0[7]}});
      else                                ex = mk(2'b11, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00);
      check_eq($sformatf("b%0d_c%0d", burst_id, c), obs(), ex);

      i = c - pre;
      start_d = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i >= 0 && i < k) begin
        valid_d = 1'b1;
        last_d  = (u == 0) && (i == n - 1);
        d1_d    = q1[i];
        d0_d    = q0[i];
      end else if (u > 0 && i == u) begin
        valid_d = 1'b0;
        last_d  = 1'($urandom_range(0, 1));
      end else begin
        valid_d = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        last_d  = 1'($urandom_range(0, 1));
        d1_d    = 8'($urandom);
        d0_d    = 8'($urandom);
      end
    end
    start_d = hold;
    valid_d = 1'b0;
    last_d  = 1'b0;
  endtask

  task automatic fill_rand(input int cnt);
    q1.delete();
    q0.delete();
    for (int j = 0; j < cnt; j++) begin
      q1.push_back(8'($urandom));
      q0.push_back(8'($urandom));
    end
  endtask

  bit sel_arr[17];
  int n_r, u_r;

  initial begin
    reset = 1'b1;
    sel = 1'b0;
    start_d = 1'b0; valid_d = 1'b0; last_d = 1'b0; d1_d = 8'h00; d0_d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_a", obs_a, mk(2'b11, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    check_eq("reset_b", obs_b, mk(2'b11, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    reset = 1'b0;

    // Directed burst of three pairs
    q1 = '{8'h11, 8'h22, 8'h33};
    q0 = '{8'hA1, 8'hA2, 8'hA3};
    run_burst(3, 0, 1'b0, 1'b0);

    // Underrun on the second HS_DATA cycle
    fill_rand(3);
    run_burst(3, 2, 1'b0, 1'b1);

    // Back-to-back with start held high
    fill_rand(4);
    run_burst(4, 0, 1'b1, 1'b1);
    fill_rand(2);
    run_burst(2, 0, 1'b0, 1'b1);

    // Reset mid CLK_PRE
    @(posedge clk) #1;
    start_d = 1'b1;
    @(posedge clk) #1;
    start_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", obs_a, mk(2'b11, 1, 1, 0, 1, 0, 0, 8'h00, 8'h00));
    reset = 1'b1;
    #1;
    check_eq("mid_rst", obs_a, mk(2'b11, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    @(posedge clk) #1;
    reset = 1'b0;
    @(posedge clk) #1;
    check_eq("post_rst", obs_a, mk(2'b11, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));

    // All timing parameters at 1
    sel = 1'b1;
    fill_rand(2);
    run_burst(2, 0, 1'b0, 1'b1);
    fill_rand(2);
    run_burst(2, 1, 1'b0, 1'b1);
    fill_rand(1);
    run_burst(1, 0, 1'b0, 1'b1);

    // Random bursts across both parameter sets
    for (int b = 0; b < 17; b++) sel_arr[b] = 1'($urandom_range(0, 1));
    for (int b = 0; b < 16; b++) begin
      sel = sel_arr[b];
      n_r = $urandom_range(1, 8);
      u_r = ($urandom_range(0, 2) == 0 && n_r > 1) ? $urandom_range(1, n_r - 1) : 0;
      fill_rand(n_r);
      run_burst(n_r, u_r, (sel_arr[b] == sel_arr[b+1]) && 1'($urandom_range(0, 1)), 1'b1);
    end
    start_d = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
